// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int unsigned PcWDefault     = 12;
  localparam int unsigned ProgEndDefault = 4095;

  typedef logic [PcWDefault-1:0] addr_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // PC action select, listed from highest to lowest priority
  typedef enum logic [2:0] {ActHold, ActHalt, ActRet, ActCall, ActJump, ActSeq} act_e;

  function automatic act_e sel_action(logic stall, logic halt, logic ret, logic call,
                                      logic jmp);
    if (stall) return ActHold;
    if (halt)  return ActHalt;
    if (ret)   return ActRet;
    if (call)  return ActCall;
    if (jmp)   return ActJump;
    return ActSeq;
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; clear wipes both the pointer and the stored entries.
module pc_sequencer_ret_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] top_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    cnt_q;
  logic [PtrW-1:0]  wr_idx, rd_idx;

  assign wr_idx  = cnt_q[PtrW-1:0];
  assign rd_idx  = wr_idx - PtrW'(1);
  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[rd_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
      cnt_q         <= cnt_q + (PtrW+1)'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - (PtrW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer: IDLE/RUN/DONE control, call/return stack, cycle counter.
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter int unsigned PC_W        = PcWDefault,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned PROG_END    = ProgEndDefault
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            BranchEn,
  input  logic            AbsJump,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Halt,
  input  logic [PC_W-1:0] Jump,
  output logic [PC_W-1:0] Prog_ctr,
  output logic            Running,
  output logic            Done,
  output logic            StackErr,
  output logic [31:0]     CycleCnt
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            push, pop, clr, full, empty;
  logic [PC_W-1:0] top;
  act_e            act;

  assign act = sel_action(Stall, Halt, Ret, Call, AbsJump | BranchEn);

  pc_sequencer_ret_stack #(
    .Depth (STACK_DEPTH),
    .Width (PC_W)
  ) u_ret_stack (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_q + PC_W'(1)),
    .full_o  (full),
    .empty_o (empty),
    .top_o   (top)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          clr     = 1'b1;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 32'd1;
        unique case (act)
          ActHold: ;
          ActHalt: state_d = StDone;
          ActRet: begin
            if (empty) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              pop  = 1'b1;
              pc_d = top;
            end
          end
          ActCall: begin
            pc_d = Jump;
            if (full) err_d = 1'b1;
            else      push  = 1'b1;
          end
          ActJump: pc_d = Jump;
          ActSeq: begin
            if (pc_q == PC_W'(PROG_END)) state_d = StDone;
            else                         pc_d    = pc_q + PC_W'(1);
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign Prog_ctr = pc_q;
  assign Running  = (state_q == StRun);
  assign Done     = (state_q == StDone);
  assign StackErr = err_q;
  assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences, random run vs reference model.
module tb_pc_sequencer;

  localparam int Depth   = 4;
  localparam int ProgEnd = 4095;

  logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Stall = 1'b0, BranchEn = 1'b0;
  logic        AbsJump = 1'b0, Call = 1'b0, Ret = 1'b0, Halt = 1'b0;
  logic [11:0] Jump = '0;
  logic [11:0] Prog_ctr;
  logic        Running, Done, StackErr;
  logic [31:0] CycleCnt;

  logic        start_e = 1'b0;
  logic [11:0] pc_e;
  logic        run_e, done_e, err_e;
  logic [31:0] cnt_e;

  int checks = 0, failures = 0;

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
    .AbsJump(AbsJump), .Call(Call), .Ret(Ret), .Halt(Halt), .Jump(Jump),
    .Prog_ctr(Prog_ctr), .Running(Running), .Done(Done), .StackErr(StackErr),
    .CycleCnt(CycleCnt)
  );

  pc_sequencer #(.PROG_END(20)) dut_e (
    .Clk(Clk), .Reset(Reset), .Start(start_e), .Stall(1'b0), .BranchEn(1'b0),
    .AbsJump(1'b0), .Call(1'b0), .Ret(1'b0), .Halt(1'b0), .Jump(12'd0),
    .Prog_ctr(pc_e), .Running(run_e), .Done(done_e), .StackErr(err_e),
    .CycleCnt(cnt_e)
  );

  // Reference model: mode 0 idle, 1 run, 2 done; stack is a queue
  int          m_mode;
  logic [11:0] m_pc;
  logic [11:0] m_stk[$];
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_stk.delete(); m_err = 1'b0; m_cnt = '0;
  endtask

  task automatic model_edge();
    if (m_mode != 1) begin
      if (Start) begin
        m_mode = 1; m_pc = '0; m_stk.delete(); m_err = 1'b0; m_cnt = '0;
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (Stall) begin
      end else if (Halt) begin
        m_mode = 2;
      end else if (Ret) begin
        if (m_stk.size() == 0) begin m_err = 1'b1; m_mode = 2; end
        else m_pc = m_stk.pop_back();
      end else if (Call) begin
        if (m_stk.size() == Depth) m_err = 1'b1;
        else m_stk.push_back(12'((int'(m_pc) + 1) % 4096));
        m_pc = Jump;
      end else if (AbsJump || BranchEn) begin
        m_pc = Jump;
      end else if (int'(m_pc) == ProgEnd) begin
        m_mode = 2;
      end else begin
        m_pc = m_pc + 12'd1;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".pc"},   32'(Prog_ctr), 32'(m_pc));
    chk({tag, ".run"},  32'(Running),  32'(m_mode == 1));
    chk({tag, ".done"}, 32'(Done),     32'(m_mode == 2));
    chk({tag, ".err"},  32'(StackErr), 32'(m_err));
    chk({tag, ".cnt"},  CycleCnt,      m_cnt);
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctl();
    Start = 0; Stall = 0; Halt = 0; Ret = 0; Call = 0; AbsJump = 0; BranchEn = 0;
  endtask

  typedef struct {
    logic        start, stall, halt, ret, call, absj, br;
    logic [11:0] jump;
    logic [11:0] e_pc;
    logic        e_run, e_done, e_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int guard;
    //                start stl hlt ret cal abs br  jump  pc   run dn err
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 12'd0,    12'd0,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'd0,    12'd1,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'd0,    12'd2,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'd0,    12'd3,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'd0,    12'd4,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'd0,    12'd5,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 12'd83,   12'd83,   1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 12'd200,  12'd83,   1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 12'd200,  12'd83,   1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 12'd200,  12'd83,   1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 12'd10,   12'd10,   1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd102,  12'd102,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd151,  12'd151,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd103,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd11,   1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd11,   0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd5,    12'd11,   0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 12'd0,    12'd0,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd20,   12'd20,   1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd30,   12'd30,   1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd40,   12'd40,   1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd50,   12'd50,   1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 12'd60,   12'd60,   1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd41,   1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd31,   1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd21,   1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd1,    1, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 12'd7,    12'd7,    1, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 1, 0, 0, 12'd99,   12'd7,    0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 12'd0,    12'd0,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 12'd0,    12'd0,    0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 12'd0,    12'd0,    1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 12'd4094, 12'd4094, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'd0,    12'd4095, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'd0,    12'd4095, 0, 1, 0});

    // Reset state
    model_reset();
    #12;
    model_check("reset");
    chk("reset.pc_e", 32'(pc_e), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    model_check("idle");

    // Short program on the PROG_END=20 instance
    start_e = 1'b1;
    @(posedge Clk); #1;
    start_e = 1'b0;
    guard = 0;
    while (!done_e && guard < 40) begin
      @(posedge Clk); #1;
      guard++;
    end
    chk("end.timeout", 32'(guard < 40), 32'd1);
    chk("end.pc",   32'(pc_e),  32'd20);
    chk("end.done", 32'(done_e), 32'd1);
    chk("end.run",  32'(run_e),  32'd0);
    chk("end.cnt",  cnt_e,       32'd21);

    // Directed vector table
    for (int i = 0; i < tbl.size(); i++) begin
      Start = tbl[i].start; Stall = tbl[i].stall; Halt = tbl[i].halt; Ret = tbl[i].ret;
      Call = tbl[i].call; AbsJump = tbl[i].absj; BranchEn = tbl[i].br; Jump = tbl[i].jump;
      step();
      chk($sformatf("vec%0d.pc", i),   32'(Prog_ctr), 32'(tbl[i].e_pc));
      chk($sformatf("vec%0d.run", i),  32'(Running),  32'(tbl[i].e_run));
      chk($sformatf("vec%0d.done", i), 32'(Done),     32'(tbl[i].e_done));
      chk($sformatf("vec%0d.err", i),  32'(StackErr), 32'(tbl[i].e_err));
      model_check($sformatf("vec%0d.m", i));
    end
    clear_ctl();

    // Async reset mid-run with two stack entries, then confirm the stack was wiped
    Start = 1; step(); Start = 0;
    Call = 1; Jump = 12'd60; step();
    Jump = 12'd42; step();
    Call = 0;
    chk("mid.pc", 32'(Prog_ctr), 32'd42);
    #3;
    Reset = 1'b0;
    #1;
    model_reset();
    chk("mid.rst_pc",  32'(Prog_ctr), 32'd0);
    chk("mid.rst_run", 32'(Running),  32'd0);
    chk("mid.rst_cnt", CycleCnt,      32'd0);
    model_check("mid.rst");
    @(posedge Clk); #1;
    Reset = 1'b1;
    Start = 1; step(); Start = 0;
    Ret = 1; step(); Ret = 0;
    chk("mid.err",  32'(StackErr), 32'd1);
    chk("mid.done", 32'(Done),     32'd1);
    model_check("mid.ret");

    // Randomised run against the model
    for (int i = 0; i < 1500; i++) begin
      Start    = ($urandom_range(0, 7) == 0);
      Stall    = ($urandom_range(0, 5) == 0);
      Halt     = ($urandom_range(0, 39) == 0);
      Ret      = ($urandom_range(0, 5) == 0);
      Call     = ($urandom_range(0, 5) == 0);
      AbsJump  = ($urandom_range(0, 9) == 0);
      BranchEn = ($urandom_range(0, 9) == 0);
      Jump     = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4090, 4095))
                                             : 12'($urandom);
      step();
      model_check("rand");
    end
    clear_ctl();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
